rf_writeback_arbiter: RTL and testbench
=======================================

// Module: rf_writeback_arbiter
// PURPOSE
//   Write-side master for the 32x32 register file's single write port (we3/wa3/wd3).
//   Merges two producers onto that port:
//     - Source A: single-cycle ALU results.
//     - Source B: variable-latency load results, buffered in an internal FIFO.
//   Issues at most one registered write per cycle and drops writes to r0.
//   Sits between the execute/LSU stages and the register file.
// PARAMETERS
//   FIFO_DEPTH  4  B-source buffer entries; power of 2, >=2
//   STARVE_MAX  3  consecutive A-grants with FIFO non-empty before B is forced; >=1
// PORTS
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous reset, active-low
//   a_valid     in   1   ALU write request
//   a_ready     out  1   ALU request accepted this cycle when a_valid & a_ready
//   a_wa        in   5   ALU destination register
//   a_wd        in   32  ALU write data
//   b_valid     in   1   load write request
//   b_ready     out  1   FIFO can accept (not full)
//   b_wa        in   5   load destination register
//   b_wd        in   32  load write data
//   we3         out  1   register-file write enable
//   wa3         out  5   register-file write address
//   wd3         out  32  register-file write data
//   fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - we3=0, wa3=0, wd3=0; FIFO emptied, fifo_count=0; starve counter=0.
//     - a_ready=1, b_ready=1.
//     - Reset mid-operation discards all FIFO contents and any pending write.
//   B push: on b_valid & b_ready. b_ready = (fifo_count != FIFO_DEPTH).
//     - Push and pop in the same cycle are both honoured; count unchanged.
//   Grant, evaluated each cycle:
//     - force = (fifo_count!=0) & (starve==STARVE_MAX).
//     - a_ready = ~force.
//     - A granted if a_valid & ~force.
//     - Else FIFO head granted (pop) if fifo_count!=0.
//     - Else no grant.
//   Starve counter:
//     - +1 on each A grant while fifo_count!=0; saturates at STARVE_MAX.
//     - Cleared on any pop or when the FIFO is empty.
//   Output register, next edge after grant:
//     - wa3/wd3 <= granted address/data.
//     - we3 <= (granted address != 0).
//     - No grant: we3<=0; wa3/wd3 hold.
//   Latency:
//     - A: accept -> we3 at next edge (1 cycle).
//     - B: push -> earliest we3 2 edges later; the FIFO is never bypassed.
//   Ordering:
//     - B writes retire in push order.
//     - No ordering between A and B; producers must not target the same register concurrently.
//   r0: writes to address 0 are accepted and consume a grant slot, but we3 stays 0.
//   FIFO pointers wrap modulo FIFO_DEPTH; occupancy never exceeds FIFO_DEPTH.
// CONFIGURATION
//   RF_WB_FWD_EN defined: adds a forwarding lookup port.
//     - Ports: fwd_ra in 5, fwd_hit out 1, fwd_data out 32.
//     - Combinational search of FIFO entries (youngest first), then the output register (only if we3=1).
//     - fwd_hit=1 with the matching data on the first match.
//     - fwd_ra==0 gives fwd_hit=0, fwd_data=0.
//     - No match gives fwd_hit=0, fwd_data=0.
//   RF_WB_FWD_EN undefined: fwd ports and search logic are absent; all other behaviour is identical.
// TESTING
//   1. Reset, then a_valid=1 a_wa=5 a_wd=32'hDEADBEEF for 1 cycle -> next cycle we3=1 wa3=5 wd3=DEADBEEF; the cycle after, we3=0.
//   2. b_valid with wa=7,8,9 on consecutive cycles, A idle -> we3 pulses wa3=7,8,9 in order, first 2 cycles after the first push.
//   3. A valid every cycle, one B push (wa=3) -> A granted 3 cycles (STARVE_MAX=3), then a_ready=0 for 1 cycle and wa3=3 written; A resumes.
//   4. 4 B pushes with A saturating -> fifo_count=4, b_ready=0; a 5th push is held and accepted once a pop frees a slot.
//   5. a_wa=0 a_wd=1 -> a_ready=1, we3 stays 0, wa3=0 wd3=1; a B push to r0 behaves the same.
//   6. rst_n low mid-drain with fifo_count=3 -> we3=0 and fifo_count=0 immediately; no stale write after release. With RF_WB_FWD_EN: fwd_ra=9 with wa=9 queued twice -> fwd_data = the younger entry.

Source files
------------

// File: rtl/rf_writeback_arbiter.sv
// Write-back arbiter for the register file write port. ALU results and FIFO-buffered load results share one registered port.
// Optional forwarding lookup port is enabled by defining RF_WB_FWD_EN.
module rf_writeback_arbiter #(
    parameter int unsigned  FIFO_DEPTH = 4,
    parameter int unsigned  STARVE_MAX = 3,
    localparam int unsigned PW         = $clog2(FIFO_DEPTH),
    localparam int unsigned CW         = PW + 1,
    localparam int unsigned SW         = $clog2(STARVE_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [4:0]    a_wa,
    input  logic [31:0]   a_wd,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [4:0]    b_wa,
    input  logic [31:0]   b_wd,
    output logic          we3,
    output logic [4:0]    wa3,
    output logic [31:0]   wd3,
    output logic [CW-1:0] fifo_count
`ifdef RF_WB_FWD_EN
    ,
    input  logic [4:0]    fwd_ra,
    output logic          fwd_hit,
    output logic [31:0]   fwd_data
`endif
);

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
    } wb_entry_t;

    wb_entry_t     mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve;

    logic      nempty_c;
    logic      force_b_c;
    logic      grant_a_c;
    logic      pop_c;
    logic      push_c;
    wb_entry_t grant_c;

    // Grant selection: A wins unless the load queue has been starved too long
    always_comb begin
        nempty_c  = (count != '0);
        force_b_c = nempty_c && (starve == SW'(STARVE_MAX));
        grant_a_c = a_valid && !force_b_c;
        pop_c     = !grant_a_c && nempty_c;
        push_c    = b_valid && b_ready;
        grant_c   = mem[rd_ptr];
        if (grant_a_c) begin
            grant_c.wa = a_wa;
            grant_c.wd = a_wd;
        end
    end

    assign a_ready    = !force_b_c;
    assign b_ready    = (count != CW'(FIFO_DEPTH));
    assign fifo_count = count;

    // Storage carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr].wa <= b_wa;
            mem[wr_ptr].wd <= b_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
            if (push_c && !pop_c)      count <= count + CW'(1);
            else if (!push_c && pop_c) count <= count - CW'(1);
        end
    end

    // Counts A grants that bypassed a waiting load; saturates at STARVE_MAX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
        end else if (pop_c || !nempty_c) begin
            starve <= '0;
        end else if (grant_a_c && (starve != SW'(STARVE_MAX))) begin
            starve <= starve + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3 <= 1'b0;
            wa3 <= '0;
            wd3 <= '0;
        end else if (grant_a_c || pop_c) begin
            we3 <= (grant_c.wa != 5'd0);
            wa3 <= grant_c.wa;
            wd3 <= grant_c.wd;
        end else begin
            we3 <= 1'b0;
        end
    end

`ifdef RF_WB_FWD_EN
    // Youngest queued entry first, then the write currently on the port
    always_comb begin
        logic [PW-1:0] idx;
        logic          found;
        idx      = '0;
        found    = 1'b0;
        fwd_data = '0;
        if (fwd_ra != 5'd0) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                idx = wr_ptr - PW'(i + 1);
                if (!found && (CW'(i) < count) && (mem[idx].wa == fwd_ra)) begin
                    found    = 1'b1;
                    fwd_data = mem[idx].wd;
                end
            end
            if (!found && we3 && (wa3 == fwd_ra)) begin
                found    = 1'b1;
                fwd_data = wd3;
            end
        end
        fwd_hit = found;
    end
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Scoreboard bench for rf_writeback_arbiter: directed stimulus queues expected writes, a monitor retires them.
module tb_rf_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [4:0]  a_wa = '0;
    logic [31:0] a_wd = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_wa = '0;
    logic [31:0] b_wd = '0;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [2:0]  fifo_count;
`ifdef RF_WB_FWD_EN
    logic [4:0]  fwd_ra = '0;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    logic [36:0] sb[$];
    int n_chk  = 0;
    int n_pass = 0;

    rf_writeback_arbiter #(.FIFO_DEPTH(4), .STARVE_MAX(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_wa       (a_wa),
        .a_wd       (a_wd),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_wa       (b_wa),
        .b_wd       (b_wd),
        .we3        (we3),
        .wa3        (wa3),
        .wd3        (wd3),
        .fifo_count (fifo_count)
`ifdef RF_WB_FWD_EN
        ,
        .fwd_ra     (fwd_ra),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every enabled write must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && we3) begin
            if (sb.size() == 0) begin
                chk("unexpected_write_wa3", 32'(wa3), 32'h0000_0000);
            end else begin
                logic [36:0] e;
                e = sb.pop_front();
                chk("sb_wa3", 32'(wa3), 32'(e[36:32]));
                chk("sb_wd3", wd3, e[31:0]);
            end
        end
    end

    // One cycle of stimulus; A writes that will be accepted go into the scoreboard
    task automatic cyc(input logic av, input logic [4:0] awa, input logic [31:0] awd, input logic exp_ar,
                       input logic bv, input logic [4:0] bwa, input logic [31:0] bwd, input logic exp_br);
        a_valid = av;
        a_wa    = awa;
        a_wd    = awd;
        b_valid = bv;
        b_wa    = bwa;
        b_wd    = bwd;
        chk("a_ready", 32'(a_ready), 32'(exp_ar));
        chk("b_ready", 32'(b_ready), 32'(exp_br));
        if (av && exp_ar && (awa != 5'd0)) sb.push_back({awa, awd});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) idle();
        idle();
        chk({name, "_pending"}, 32'(sb.size()), 32'd0);
        chk({name, "_fifo_count"}, 32'(fifo_count), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we3", 32'(we3), 32'd0);
        chk("rst_wa3", 32'(wa3), 32'd0);
        chk("rst_wd3", wd3, 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd1);
        chk("rst_b_ready", 32'(b_ready), 32'd1);
        rst_n = 1'b1;
        idle();

        // Single ALU write, one-cycle latency
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
        a_valid = 1'b0;
        chk("t1_we3", 32'(we3), 32'd1);
        chk("t1_wa3", 32'(wa3), 32'd5);
        chk("t1_wd3", wd3, 32'hDEADBEEF);
        idle();
        chk("t1_we3_low", 32'(we3), 32'd0);

        // Three loads, retired in push order, two edges after the first push
        sb.push_back({5'd7, 32'h0000_0707});
        sb.push_back({5'd8, 32'h0000_0808});
        sb.push_back({5'd9, 32'h0000_0909});
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd7, 32'h0000_0707, 1'b1);
        chk("t2_we3_first_edge", 32'(we3), 32'd0);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd8, 32'h0000_0808, 1'b1);
        chk("t2_we3_second_edge", 32'(we3), 32'd1);
        chk("t2_wa3_second_edge", 32'(wa3), 32'd7);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd9, 32'h0000_0909, 1'b1);
        drain("t2");

        // Starvation: the queued load is forced after STARVE_MAX bypassing A grants
        cyc(1'b1, 5'd10, 32'h10, 1'b1, 1'b1, 5'd3, 32'h333, 1'b1);
        cyc(1'b1, 5'd11, 32'h11, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
        cyc(1'b1, 5'd12, 32'h12, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
        cyc(1'b1, 5'd13, 32'h13, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
        sb.push_back({5'd3, 32'h333});
        cyc(1'b1, 5'd14, 32'h14, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        chk("t3_forced_wa3", 32'(wa3), 32'd3);
        cyc(1'b1, 5'd14, 32'h14, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
        drain("t3");

        // FIFO full: fifth push stalls until the forced pop frees a slot
        cyc(1'b1, 5'd1, 32'h100, 1'b1, 1'b1, 5'd20, 32'h200, 1'b1);
        cyc(1'b1, 5'd2, 32'h101, 1'b1, 1'b1, 5'd21, 32'h201, 1'b1);
        cyc(1'b1, 5'd3, 32'h102, 1'b1, 1'b1, 5'd22, 32'h202, 1'b1);
        cyc(1'b1, 5'd4, 32'h103, 1'b1, 1'b1, 5'd23, 32'h203, 1'b1);
        chk("t4_full_count", 32'(fifo_count), 32'd4);
        sb.push_back({5'd20, 32'h200});
        cyc(1'b1, 5'd5, 32'h104, 1'b0, 1'b1, 5'd24, 32'h204, 1'b0);
        chk("t4_after_pop_count", 32'(fifo_count), 32'd3);
        cyc(1'b1, 5'd5, 32'h104, 1'b1, 1'b1, 5'd24, 32'h204, 1'b1);
        chk("t4_refill_count", 32'(fifo_count), 32'd4);
        sb.push_back({5'd21, 32'h201});
        sb.push_back({5'd22, 32'h202});
        sb.push_back({5'd23, 32'h203});
        sb.push_back({5'd24, 32'h204});
        drain("t4");

        // r0 writes take a slot but never enable the port
        cyc(1'b1, 5'd0, 32'd1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
        a_valid = 1'b0;
        chk("t5a_we3", 32'(we3), 32'd0);
        chk("t5a_wa3", 32'(wa3), 32'd0);
        chk("t5a_wd3", wd3, 32'd1);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd0, 32'd2, 1'b1);
        idle();
        chk("t5b_we3", 32'(we3), 32'd0);
        chk("t5b_wa3", 32'(wa3), 32'd0);
        chk("t5b_wd3", wd3, 32'd2);
        chk("t5b_fifo_count", 32'(fifo_count), 32'd0);

        // Reset mid-drain discards queued loads and the pending write
        cyc(1'b1, 5'd1, 32'h601, 1'b1, 1'b1, 5'd25, 32'h625, 1'b1);
        cyc(1'b1, 5'd2, 32'h602, 1'b1, 1'b1, 5'd26, 32'h626, 1'b1);
        cyc(1'b1, 5'd3, 32'h603, 1'b1, 1'b1, 5'd27, 32'h627, 1'b1);
        cyc(1'b1, 5'd4, 32'h604, 1'b1, 1'b1, 5'd28, 32'h628, 1'b1);
        idle();
        chk("t6_pre_count", 32'(fifo_count), 32'd3);
        chk("t6_pre_we3", 32'(we3), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_we3", 32'(we3), 32'd0);
        chk("t6_rst_count", 32'(fifo_count), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) idle();
        chk("t6_post_we3", 32'(we3), 32'd0);
        chk("t6_post_count", 32'(fifo_count), 32'd0);

`ifdef RF_WB_FWD_EN
        // Forwarding returns the younger of two queued writes to the same register
        cyc(1'b1, 5'd1, 32'h701, 1'b1, 1'b1, 5'd9, 32'hAAAA, 1'b1);
        cyc(1'b1, 5'd2, 32'h702, 1'b1, 1'b1, 5'd9, 32'hBBBB, 1'b1);
        a_valid = 1'b0;
        b_valid = 1'b0;
        fwd_ra  = 5'd9;
        #1;
        chk("fwd_hit_r9", 32'(fwd_hit), 32'd1);
        chk("fwd_data_r9", fwd_data, 32'hBBBB);
        fwd_ra = 5'd0;
        #1;
        chk("fwd_hit_r0", 32'(fwd_hit), 32'd0);
        chk("fwd_data_r0", fwd_data, 32'd0);
        fwd_ra = 5'd17;
        #1;
        chk("fwd_hit_miss", 32'(fwd_hit), 32'd0);
        chk("fwd_data_miss", fwd_data, 32'd0);
        sb.push_back({5'd9, 32'hAAAA});
        sb.push_back({5'd9, 32'hBBBB});
        drain("fwd");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
